// File: rtl/axi_wr_req_arbiter.sv
// Four-way round-robin front end for a single AXI write-channel controller.
// Issues one write at a time, routes the response back, and guards it with a watchdog.
module axi_wr_req_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                AClk,
    input  logic                ARst,
    input  logic [3:0]          req_valid,
    input  logic [4*ADDR_W-1:0] req_addr,
    input  logic [15:0]         req_len,
    input  logic [7:0]          req_burst,
    input  logic [11:0]         req_size,
    input  logic [4*DATA_W-1:0] req_wdata,
    input  logic [4*STRB_W-1:0] req_wstrb,
    output logic [3:0]          req_ready,
    output logic [3:0]          gnt,
    output logic [3:0]          rsp_valid,
    output logic [1:0]          rsp_resp,
    output logic [ADDR_W-1:0]   awaddr_d,
    output logic [3:0]          TXN_ID_W_d,
    output logic [1:0]          awburst_d,
    output logic [3:0]          awlen_d,
    output logic [2:0]          awsize_d,
    output logic [1:0]          awlock_d,
    output logic [1:0]          awcache_d,
    output logic [2:0]          awprot_d,
    output logic [DATA_W-1:0]   wdata_d,
    output logic [STRB_W-1:0]   wstrb_d,
    output logic                wr_trn_en,
    input  logic [1:0]          bresp_d,
    input  logic [3:0]          bid_d,
    input  logic                wr_rsp_en_d,
    output logic                timeout_err,
    output logic                id_err,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StDrain} state_e;

    state_e              state_q, state_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [1:0]          gidx_q, gidx_d;
    logic [1:0]          tag_q, tag_d;
    logic [3:0]          id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic [2:0]          size_q, size_d;
    logic [15:0]         wd_q, wd_d;
    logic [3:0]          rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                timeout_err_q, timeout_err_d;
    logic                id_err_q, id_err_d;

    logic                arb_found;
    logic [1:0]          arb_idx;
    logic [1:0]          arb_cand;
    logic [16:0]         wd_inc;

    assign wd_inc = {1'b0, wd_q} + 17'd1;

    // Scan from the requester after the last winner, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        arb_cand  = rr_ptr_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            arb_cand = rr_ptr_q + 2'(k);
            if (!arb_found && req_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_ff @(posedge AClk) begin
        if (!ARst) begin
            state_q       <= StIdle;
            rr_ptr_q      <= 2'd3;
            gidx_q        <= 2'd0;
            tag_q         <= 2'd0;
            id_q          <= 4'd0;
            addr_q        <= '0;
            len_q         <= 4'd0;
            burst_q       <= 2'd0;
            size_q        <= 3'd0;
            wd_q          <= 16'd0;
            rsp_valid_q   <= 4'd0;
            rsp_resp_q    <= 2'd0;
            timeout_err_q <= 1'b0;
            id_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gidx_q        <= gidx_d;
            tag_q         <= tag_d;
            id_q          <= id_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            burst_q       <= burst_d;
            size_q        <= size_d;
            wd_q          <= wd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_resp_q    <= rsp_resp_d;
            timeout_err_q <= timeout_err_d;
            id_err_q      <= id_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gidx_d        = gidx_q;
        tag_d         = tag_q;
        id_d          = id_q;
        addr_d        = addr_q;
        len_d         = len_q;
        burst_d       = burst_q;
        size_d        = size_q;
        wd_d          = wd_q;
        rsp_valid_d   = 4'd0;
        rsp_resp_d    = 2'd0;
        timeout_err_d = timeout_err_q;
        id_err_d      = id_err_q;

        unique case (state_q)
            StIdle: begin
                if (wr_rsp_en_d) begin
                    id_err_d = 1'b1;
                end
                // Hold off arbitration while the previous response is being delivered.
                if (arb_found && (rsp_valid_q == 4'd0)) begin
                    gidx_d   = arb_idx;
                    rr_ptr_d = arb_idx;
                    id_d     = {tag_q, arb_idx};
                    addr_d   = req_addr[arb_idx*ADDR_W +: ADDR_W];
                    len_d    = req_len[arb_idx*4 +: 4];
                    burst_d  = req_burst[arb_idx*2 +: 2];
                    size_d   = req_size[arb_idx*3 +: 3];
                    wd_d     = 16'd0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (wr_rsp_en_d) begin
                    id_err_d = 1'b1;
                end
                tag_d   = tag_q + 2'd1;
                wd_d    = wd_inc[15:0];
                state_d = StWaitRsp;
            end
            StWaitRsp: begin
                wd_d = wd_inc[15:0];
                if (wr_rsp_en_d) begin
                    rsp_valid_d = 4'b0001 << gidx_q;
                    if (bid_d != id_q) begin
                        rsp_resp_d = 2'b10;
                        id_err_d   = 1'b1;
                    end else begin
                        rsp_resp_d = bresp_d;
                    end
                    state_d = StIdle;
                end else if (wd_inc >= 17'(TIMEOUT)) begin
                    rsp_valid_d   = 4'b0001 << gidx_q;
                    rsp_resp_d    = 2'b10;
                    timeout_err_d = 1'b1;
                    state_d       = StDrain;
                end
            end
            StDrain: begin
                if (wr_rsp_en_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_trn_en   = 1'b0;
        req_ready   = 4'd0;
        gnt         = 4'd0;
        wdata_d     = '0;
        wstrb_d     = '0;
        busy        = (state_q != StIdle);
        rsp_valid   = rsp_valid_q;
        rsp_resp    = rsp_resp_q;
        awaddr_d    = addr_q;
        TXN_ID_W_d  = id_q;
        awburst_d   = burst_q;
        awlen_d     = len_q;
        awsize_d    = size_q;
        awlock_d    = 2'd0;
        awcache_d   = 2'd0;
        awprot_d    = 3'd0;
        timeout_err = timeout_err_q;
        id_err      = id_err_q;
        if (state_q == StIssue) begin
            wr_trn_en = 1'b1;
            req_ready = 4'b0001 << gidx_q;
        end
        if (state_q == StIssue || state_q == StWaitRsp) begin
            gnt = 4'b0001 << gidx_q;
        end
        if (state_q != StIdle) begin
            wdata_d = req_wdata[gidx_q*DATA_W +: DATA_W];
            wstrb_d = req_wstrb[gidx_q*STRB_W +: STRB_W];
        end
    end

endmodule

// File: tb/tb_axi_wr_req_arbiter.sv
// Directed and randomized checks of the write-request arbiter against a
// round-robin / tag-counter reference model.
module tb_axi_wr_req_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 8;
    localparam int unsigned TO = 16;

    logic            AClk = 1'b0;
    logic            ARst = 1'b0;
    logic [3:0]      req_valid = '0;
    logic [4*AW-1:0] req_addr = '0;
    logic [15:0]     req_len = '0;
    logic [7:0]      req_burst = '0;
    logic [11:0]     req_size = '0;
    logic [4*DW-1:0] req_wdata = '0;
    logic [4*SW-1:0] req_wstrb = '0;
    logic [3:0]      req_ready, gnt, rsp_valid;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   awaddr_d;
    logic [3:0]      TXN_ID_W_d;
    logic [1:0]      awburst_d;
    logic [3:0]      awlen_d;
    logic [2:0]      awsize_d;
    logic [1:0]      awlock_d, awcache_d;
    logic [2:0]      awprot_d;
    logic [DW-1:0]   wdata_d;
    logic [SW-1:0]   wstrb_d;
    logic            wr_trn_en;
    logic [1:0]      bresp_d = '0;
    logic [3:0]      bid_d = '0;
    logic            wr_rsp_en_d = 1'b0;
    logic            timeout_err, id_err, busy;

    axi_wr_req_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .STRB_W (SW),
        .TIMEOUT(TO)
    ) dut (
        .AClk       (AClk),
        .ARst       (ARst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_burst  (req_burst),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_ready  (req_ready),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_resp   (rsp_resp),
        .awaddr_d   (awaddr_d),
        .TXN_ID_W_d (TXN_ID_W_d),
        .awburst_d  (awburst_d),
        .awlen_d    (awlen_d),
        .awsize_d   (awsize_d),
        .awlock_d   (awlock_d),
        .awcache_d  (awcache_d),
        .awprot_d   (awprot_d),
        .wdata_d    (wdata_d),
        .wstrb_d    (wstrb_d),
        .wr_trn_en  (wr_trn_en),
        .bresp_d    (bresp_d),
        .bid_d      (bid_d),
        .wr_rsp_en_d(wr_rsp_en_d),
        .timeout_err(timeout_err),
        .id_err     (id_err),
        .busy       (busy)
    );

    always #5 AClk = ~AClk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr;
    int          m_tag;
    logic        m_id_err;
    logic        m_to_err;
    logic [31:0] m_addr[4];
    logic [3:0]  m_len[4];
    logic [1:0]  m_burst[4];
    logic [2:0]  m_size[4];
    logic [63:0] m_wdata[4];
    logic [7:0]  m_wstrb[4];

    task automatic step();
        @(posedge AClk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] mask, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_grant(input logic [3:0] mask, output int g, output logic [3:0] id);
        g     = pick(mask, m_ptr);
        m_ptr = g;
        id    = {2'(m_tag), 2'(g)};
        m_tag = (m_tag + 1) % 4;
    endtask

    task automatic drive_slices();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*AW +: AW]  = m_addr[i];
            req_len[i*4 +: 4]     = m_len[i];
            req_burst[i*2 +: 2]   = m_burst[i];
            req_size[i*3 +: 3]    = m_size[i];
            req_wdata[i*DW +: DW] = m_wdata[i];
            req_wstrb[i*SW +: SW] = m_wstrb[i];
        end
    endtask

    task automatic randomize_slices();
        for (int i = 0; i < 4; i++) begin
            m_addr[i]  = $urandom;
            m_len[i]   = 4'($urandom);
            m_burst[i] = 2'($urandom);
            m_size[i]  = 3'($urandom);
            m_wdata[i] = {$urandom, $urandom};
            m_wstrb[i] = 8'($urandom);
        end
        drive_slices();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_trn"}, 64'(wr_trn_en), 64'd0);
        chk({tag, "_rspv"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_resp"}, 64'(rsp_resp), 64'd0);
        chk({tag, "_addr"}, 64'(awaddr_d), 64'd0);
        chk({tag, "_id"}, 64'(TXN_ID_W_d), 64'd0);
        chk({tag, "_len"}, 64'(awlen_d), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata_d), 64'd0);
        chk({tag, "_toerr"}, 64'(timeout_err), 64'd0);
        chk({tag, "_iderr"}, 64'(id_err), 64'd0);
    endtask

    task automatic do_reset();
        ARst        = 1'b0;
        req_valid   = 4'd0;
        wr_rsp_en_d = 1'b0;
        step();
        step();
        chk_zero("rst");
        ARst     = 1'b1;
        m_ptr    = 3;
        m_tag    = 0;
        m_id_err = 1'b0;
        m_to_err = 1'b0;
    endtask

    task automatic chk_issue(input string tag, input int g, input logic [3:0] id);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        chk({tag, "_trn"}, 64'(wr_trn_en), 64'd1);
        chk({tag, "_ready"}, 64'(req_ready), 64'(oh));
        chk({tag, "_gnt"}, 64'(gnt), 64'(oh));
        chk({tag, "_addr"}, 64'(awaddr_d), 64'(m_addr[g]));
        chk({tag, "_len"}, 64'(awlen_d), 64'(m_len[g]));
        chk({tag, "_burst"}, 64'(awburst_d), 64'(m_burst[g]));
        chk({tag, "_size"}, 64'(awsize_d), 64'(m_size[g]));
        chk({tag, "_id"}, 64'(TXN_ID_W_d), 64'(id));
        chk({tag, "_attr"}, 64'({awlock_d, awcache_d, awprot_d}), 64'd0);
    endtask

    task automatic wait_trn(input string tag, input int bound, output int steps);
        steps = 0;
        while (!wr_trn_en && steps < bound) begin
            step();
            steps++;
        end
        chk({tag, "_trn_seen"}, 64'(wr_trn_en), 64'd1);
    endtask

    task automatic respond(input logic [3:0] bid, input logic [1:0] br);
        wr_rsp_en_d = 1'b1;
        bid_d       = bid;
        bresp_d     = br;
        step();
        wr_rsp_en_d = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          g, st, d;
        logic [3:0]  id, mask, bid;
        logic [1:0]  br;
        logic        bad;

        for (int i = 0; i < 4; i++) begin
            m_addr[i] = '0; m_len[i] = '0; m_burst[i] = '0; m_size[i] = '0;
            m_wdata[i] = '0; m_wstrb[i] = '0;
        end
        do_reset();

        // Single transaction from requester 0
        m_addr[0] = 32'h1000; m_len[0] = 4'd3; m_burst[0] = 2'b01; m_size[0] = 3'd3;
        drive_slices();
        req_valid = 4'b0001;
        step();
        model_grant(4'b0001, g, id);
        chk_issue("t1", g, id);
        chk("t1_id_const", 64'(TXN_ID_W_d), 64'h0);
        req_valid = 4'b0000;
        step();
        chk("t1_wait_trn", 64'(wr_trn_en), 64'd0);
        chk("t1_wait_gnt", 64'(gnt), 64'b0001);
        chk("t1_wait_busy", 64'(busy), 64'd1);
        respond(4'h0, 2'b00);
        chk("t1_rspv", 64'(rsp_valid), 64'b0001);
        chk("t1_resp", 64'(rsp_resp), 64'd0);
        chk("t1_gnt_clr", 64'(gnt), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);

        // Fairness with all four requesting, plus back-to-back latency
        do_reset();
        randomize_slices();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            wait_trn("fair", 10, st);
            chk("fair_lat", 64'(st), (i == 0) ? 64'd1 : 64'd2);
            model_grant(4'b1111, g, id);
            chk_issue("fair", g, id);
            step();
            br = 2'($urandom);
            respond(id, br);
            chk("fair_rspv", 64'(rsp_valid), 64'(4'b0001 << g));
            chk("fair_resp", 64'(rsp_resp), 64'(br));
        end
        req_valid = 4'b0000;

        // Wrong response ID from requester 2
        do_reset();
        req_valid = 4'b0100;
        wait_trn("iderr", 10, st);
        model_grant(4'b0100, g, id);
        chk_issue("iderr", g, id);
        req_valid = 4'b0000;
        step();
        respond(4'h3, 2'b00);
        m_id_err = 1'b1;
        chk("iderr_rspv", 64'(rsp_valid), 64'b0100);
        chk("iderr_resp", 64'(rsp_resp), 64'b10);
        chk("iderr_flag", 64'(id_err), 64'(m_id_err));
        for (int i = 0; i < 3; i++) step();
        chk("iderr_sticky", 64'(id_err), 64'd1);

        // Watchdog expiry, drain, late response
        do_reset();
        randomize_slices();
        req_valid = 4'b0001;
        step();
        model_grant(4'b0001, g, id);
        chk_issue("to", g, id);
        req_valid = 4'b0000;
        for (int i = 0; i < 15; i++) step();
        chk("to_pre_rspv", 64'(rsp_valid), 64'd0);
        chk("to_pre_gnt", 64'(gnt), 64'b0001);
        step();
        m_to_err = 1'b1;
        chk("to_rspv", 64'(rsp_valid), 64'b0001);
        chk("to_resp", 64'(rsp_resp), 64'b10);
        chk("to_flag", 64'(timeout_err), 64'(m_to_err));
        chk("to_busy", 64'(busy), 64'd1);
        chk("to_gnt", 64'(gnt), 64'd0);
        req_valid = 4'b0010;
        step();
        step();
        chk("drain_trn", 64'(wr_trn_en), 64'd0);
        chk("drain_busy", 64'(busy), 64'd1);
        respond(4'($urandom), 2'b00);
        chk("drain_rspv", 64'(rsp_valid), 64'd0);
        chk("drain_busy_off", 64'(busy), 64'd0);
        chk("drain_iderr", 64'(id_err), 64'd0);
        step();
        model_grant(4'b0010, g, id);
        chk_issue("post", g, id);
        req_valid = 4'b0000;
        step();

        // Write data follows the granted slice combinationally
        m_wdata[1] = {$urandom, $urandom};
        m_wstrb[1] = 8'($urandom);
        drive_slices();
        #1;
        chk("wd_follow", 64'(wdata_d), 64'(m_wdata[1]));
        chk("ws_follow", 64'(wstrb_d), 64'(m_wstrb[1]));
        m_wdata[0] = ~m_wdata[0];
        drive_slices();
        #1;
        chk("wd_other", 64'(wdata_d), 64'(m_wdata[1]));

        // Response on the same cycle the watchdog expires: response wins
        for (int i = 0; i < 14; i++) step();
        respond(id, 2'b01);
        chk("race_rspv", 64'(rsp_valid), 64'b0010);
        chk("race_resp", 64'(rsp_resp), 64'b01);
        chk("race_busy", 64'(busy), 64'd0);
        chk("race_toerr", 64'(timeout_err), 64'(m_to_err));

        // Reset during WAIT_RSP
        req_valid = 4'b0100;
        wait_trn("mid", 10, st);
        model_grant(4'b0100, g, id);
        req_valid = 4'b0000;
        step();
        ARst = 1'b0;
        req_valid = 4'b0101;
        step();
        chk_zero("mid_rst");
        m_ptr = 3; m_tag = 0; m_id_err = 1'b0; m_to_err = 1'b0;
        ARst = 1'b1;
        step();
        model_grant(4'b0101, g, id);
        chk_issue("mid_first", g, id);
        req_valid = 4'b0000;
        step();
        respond(id, 2'b00);
        chk("mid_rspv", 64'(rsp_valid), 64'b0001);

        // Stray response while idle
        step();
        respond(4'h0, 2'b00);
        m_id_err = 1'b1;
        chk("stray_iderr", 64'(id_err), 64'(m_id_err));
        chk("stray_rspv", 64'(rsp_valid), 64'd0);
        chk("stray_busy", 64'(busy), 64'd0);

        // Randomized transactions
        do_reset();
        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(1, 15));
            randomize_slices();
            req_valid = mask;
            wait_trn("rnd", 10, st);
            model_grant(mask, g, id);
            chk_issue("rnd", g, id);
            req_valid = 4'b0000;
            d   = $urandom_range(0, 17);
            bad = ($urandom_range(0, 3) == 0);
            br  = 2'($urandom);
            step();
            chk("rnd_wdata", 64'(wdata_d), 64'(m_wdata[g]));
            chk("rnd_wstrb", 64'(wstrb_d), 64'(m_wstrb[g]));
            if (d <= 14) begin
                for (int j = 0; j < d; j++) step();
                bid = bad ? (id ^ 4'($urandom_range(1, 15))) : id;
                respond(bid, br);
                if (bad) m_id_err = 1'b1;
                chk("rnd_rspv", 64'(rsp_valid), 64'(4'b0001 << g));
                chk("rnd_resp", 64'(rsp_resp), bad ? 64'b10 : 64'(br));
                chk("rnd_busy", 64'(busy), 64'd0);
            end else begin
                for (int j = 0; j < 15; j++) step();
                m_to_err = 1'b1;
                chk("rnd_to_rspv", 64'(rsp_valid), 64'(4'b0001 << g));
                chk("rnd_to_resp", 64'(rsp_resp), 64'b10);
                chk("rnd_to_busy", 64'(busy), 64'd1);
                step();
                respond(4'($urandom), br);
                chk("rnd_drain_rspv", 64'(rsp_valid), 64'd0);
                chk("rnd_drain_busy", 64'(busy), 64'd0);
            end
            chk("rnd_iderr", 64'(id_err), 64'(m_id_err));
            chk("rnd_toerr", 64'(timeout_err), 64'(m_to_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_req_arbiter.md
Name: axi_wr_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one AXI master write-channel controller among 4 requesters.
- Latches the winning requester's address/control fields and issues a single-cycle wr_trn_en to the controller.
- Muxes the winner's write data/strobe through with zero latency, then routes the write response back to that requester.
- Enforces one outstanding write at a time, with a response watchdog, transaction-ID tagging and sticky error flags.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, write data width (8..1024).
- STRB_W, DATA_W/8, strobe width.
- TIMEOUT, 1024, cycles in WAIT_RSP before the watchdog fires (16-bit counter, 1..65535).

Ports:
- AClk  in  1  clock.
- ARst  in  1  synchronous active-low reset.
- req_valid  in  4  per-requester write request; held until req_ready.
- req_addr  in  4*ADDR_W  packed start addresses; slice i = requester i.
- req_len  in  16  packed 4-bit burst lengths (beats-1).
- req_burst  in  8  packed 2-bit burst types.
- req_size  in  12  packed 3-bit beat sizes.
- req_wdata  in  4*DATA_W  packed write data.
- req_wstrb  in  4*STRB_W  packed strobes.
- req_ready  out  4  one-cycle accept pulse to the winner.
- gnt  out  4  one-hot; set from ISSUE until rsp_valid.
- rsp_valid  out  4  one-cycle response strobe to the owner.
- rsp_resp  out  2  response code, valid with rsp_valid.
- awaddr_d  out  ADDR_W  to controller.
- TXN_ID_W_d  out  4  to controller.
- awburst_d  out  2  to controller.
- awlen_d  out  4  to controller.
- awsize_d  out  3  to controller.
- awlock_d  out  2  to controller.
- awcache_d  out  2  to controller.
- awprot_d  out  3  to controller.
- wdata_d  out  DATA_W  to controller.
- wstrb_d  out  STRB_W  to controller.
- wr_trn_en  out  1  one-cycle transaction start.
- bresp_d  in  2  response from controller.
- bid_d  in  4  response ID from controller.
- wr_rsp_en_d  in  1  response-valid pulse from controller.
- timeout_err  out  1  sticky.
- id_err  out  1  sticky.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: ARst=0 sampled on a rising AClk edge, including mid-transaction.
  - State=IDLE; all outputs 0; rr_ptr=3 (requester 0 wins first); tag=0; watchdog=0; sticky flags cleared.
- States: IDLE, ISSUE, WAIT_RSP, DRAIN.
- IDLE:
  - If any req_valid, pick the first set bit scanning from rr_ptr+1 mod 4.
  - Latch its addr/len/burst/size. Set grant index g and rr_ptr=g. Go to ISSUE.
  - If no req_valid, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - wr_trn_en=1, req_ready[g]=1, gnt[g]=1.
  - TXN_ID_W_d={tag,g}; awlock_d=0, awcache_d=0, awprot_d=0.
  - Next state WAIT_RSP; tag increments (2-bit, wraps 3->0).
- WAIT_RSP:
  - wr_trn_en=0. Control outputs held from the latch.
  - wdata_d/wstrb_d are combinational slices of requester g (0 in IDLE).
  - Watchdog counts 1 per cycle.
  - On wr_rsp_en_d: next cycle rsp_valid[g]=1, gnt cleared, state IDLE.
    - If bid_d != issued ID: rsp_resp=2'b10 and id_err set.
    - Otherwise rsp_resp=bresp_d.
  - If the watchdog reaches TIMEOUT first: next cycle rsp_valid[g]=1, rsp_resp=2'b10, timeout_err set, gnt cleared, state DRAIN.
- DRAIN:
  - No new grants; busy=1.
  - On wr_rsp_en_d (the late response, discarded), go to IDLE.
- Response arriving in the same cycle the watchdog reaches TIMEOUT: the response wins; no timeout.
- wr_rsp_en_d in IDLE or ISSUE: ignored and sets id_err.
- A requester dropping req_valid before req_ready does not cancel a grant already latched.
- Throughput:
  - req_valid at cycle 0 in IDLE -> wr_trn_en and req_ready at cycle 1.
  - Response at cycle n -> rsp_valid at n+1 -> earliest next wr_trn_en at n+3.
- Fairness: with all 4 requesting continuously, the grant order is 0,1,2,3,0,...

Test Plan:
- Reset then req_valid=4'b0001, addr0=0x1000, len0=3, burst=INCR -> cycle 1: wr_trn_en=1, req_ready=0001, awaddr_d=0x1000, awlen_d=3, TXN_ID_W_d=4'h0; wr_rsp_en_d with bid_d=4'h0, bresp_d=00 -> next cycle rsp_valid=0001, rsp_resp=00.
- req_valid=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; TXN_ID_W_d = 0x0,0x5,0xA,0xF,0x0,...
- Requester 2 granted, controller returns bid_d=4'h3 -> rsp_valid=0100, rsp_resp=10, id_err=1 sticky until reset.
- TIMEOUT=16, no response -> 16 cycles after ISSUE: rsp_valid=0001, rsp_resp=10, timeout_err=1, busy=1; late wr_rsp_en_d -> IDLE, no rsp_valid.
- While granted to 1, change req_wdata slice 1 -> wdata_d follows in the same cycle; slice 0 changes do not appear on wdata_d.
- ARst=0 during WAIT_RSP -> next cycle all outputs 0, state IDLE; after release, requester 0 wins first.
